tm1638_key_reader: RTL

- Reads the TM1638 key-scan matrix over the same STB/CLK/DIO serial bus that the display driver writes to.
- Sends the read-key command 0x42, releases DIO, clocks in 4 scan bytes, and decodes them into an 8-key vector for the LED&KEY board.
- The parent shares the bus with the display driver: it routes tm_stb/tm_clk/DIO to this block while busy=1, otherwise to the driver.

---
 rtl/tm1638_key_if.sv | 40 ++++
 rtl/tm1638_key_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_key_if.sv
// TM1638 key-reader bus bundle: scan handshake, decoded results and the STB/CLK/DIO pins.
// The parent (or testbench) uses the master modport; the reader uses the slave modport.
interface tm1638_key_if;
  logic        start;
  logic        busy;
  logic        valid;
  logic [7:0]  keys;
  logic [31:0] key_raw;
  logic        tm_stb;
  logic        tm_clk;
  logic        dio_out;
  logic        dio_oe;
  logic        dio_in;

  modport master (
    output start,
    output dio_in,
    input  busy,
    input  valid,
    input  keys,
    input  key_raw,
    input  tm_stb,
    input  tm_clk,
    input  dio_out,
    input  dio_oe
  );

  modport slave (
    input  start,
    input  dio_in,
    output busy,
    output valid,
    output keys,
    output key_raw,
    output tm_stb,
    output tm_clk,
    output dio_out,
    output dio_oe
  );
endinterface

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends read-key command 0x42, releases DIO, clocks in 4 scan bytes
// and decodes them into the 8 keys of the LED&KEY board.
// Optional feature: define TM1638_KEY_AUTOPOLL_EN to start a scan every POLL_CYC cycles
// (a poll that lands while a scan is in progress is dropped).
module tm1638_key_reader #(
  parameter int unsigned CLK_DIV  = 25,      // system cycles per tm_clk half-period, >= 4
  parameter int unsigned WAIT_CYC = 50,      // command-to-read gap (Twait)
  parameter int unsigned POLL_CYC = 2500000  // auto-poll interval
) (
  input logic          clk,
  input logic          rst,
  tm1638_key_if.slave  bus
);

  localparam logic [7:0]  Cmd    = 8'h42;
  localparam int unsigned CntMax = (CLK_DIV > WAIT_CYC) ? CLK_DIV : WAIT_CYC;
  localparam int unsigned CntW   = $clog2(CntMax);

  // Elaboration-time sanity check of the configuration
  if (CLK_DIV < 4 || WAIT_CYC < 1 || POLL_CYC < 1) begin : gen_bad_param
    $error("tm1638_key_reader: illegal parameter value");
  end

  typedef enum logic [2:0] {StIdle, StCmd, StWait, StRead, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic            phase_q, phase_d;  // 0: tm_clk low phase, 1: high phase
  logic [31:0]     shadow_q, shadow_d;
  logic [31:0]     key_raw_q, key_raw_d;
  logic [7:0]      keys_q, keys_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            tm_stb_q, tm_stb_d;
  logic            tm_clk_q, tm_clk_d;
  logic            dio_out_q, dio_out_d;
  logic            dio_oe_q, dio_oe_d;
  logic            dio_meta_q, dio_sync_q;
  logic            start_req;
  logic            half_done;
  logic [2:0]      cmd_nxt;

  // Map raw scan bytes to keys: byte k bit0 -> S(k+1), bit4 -> S(k+5)
  function automatic logic [7:0] decode_keys(input logic [31:0] raw);
    logic [7:0] k;
    for (int i = 0; i < 4; i++) begin
      k[i]     = raw[8*i];
      k[i + 4] = raw[8*i + 4];
    end
    return k;
  endfunction

`ifdef TM1638_KEY_AUTOPOLL_EN
  localparam int unsigned PollW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;

  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
  logic             poll_wrap;

  // Free-running poll interval counter
  always_comb begin
    poll_wrap  = (poll_cnt_q == PollW'(POLL_CYC - 1));
    poll_cnt_d = poll_wrap ? '0 : poll_cnt_q + PollW'(1);
  end

  // Poll counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) poll_cnt_q <= '0;
    else     poll_cnt_q <= poll_cnt_d;
  end

  assign start_req = bus.start | poll_wrap;
`else
  assign start_req = bus.start;
`endif

  // Two-flop synchronizer for the DIO pad input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dio_meta_q <= 1'b1;
      dio_sync_q <= 1'b1;
    end else begin
      dio_meta_q <= bus.dio_in;
      dio_sync_q <= dio_meta_q;
    end
  end

  assign half_done = (cnt_q == CntW'(CLK_DIV - 1));
  assign cmd_nxt   = bit_q[2:0] + 3'd1;

  // Next-state and next-output logic; outputs are computed for the cycle being entered
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    shadow_d  = shadow_q;
    key_raw_d = key_raw_q;
    keys_d    = keys_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    tm_stb_d  = tm_stb_q;
    tm_clk_d  = tm_clk_q;
    dio_out_d = dio_out_q;
    dio_oe_d  = dio_oe_q;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start_req) begin
          state_d   = StCmd;
          cnt_d     = '0;
          bit_d     = '0;
          phase_d   = 1'b0;
          busy_d    = 1'b1;
          tm_stb_d  = 1'b0;
          tm_clk_d  = 1'b0;
          dio_oe_d  = 1'b1;
          dio_out_d = Cmd[0];
        end
      end

      StCmd: begin
        cnt_d = cnt_q + CntW'(1);
        if (half_done) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d  = 1'b1;
            tm_clk_d = 1'b1;
          end else if (bit_q == 5'd7) begin
            // Release DIO so the device can drive the scan data
            state_d   = StWait;
            tm_clk_d  = 1'b1;
            dio_oe_d  = 1'b0;
            dio_out_d = 1'b1;
          end else begin
            phase_d   = 1'b0;
            bit_d     = bit_q + 5'd1;
            tm_clk_d  = 1'b0;
            dio_out_d = Cmd[cmd_nxt];
          end
        end
      end

      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WAIT_CYC - 1)) begin
          state_d  = StRead;
          cnt_d    = '0;
          bit_d    = '0;
          phase_d  = 1'b0;
          tm_clk_d = 1'b0;
        end
      end

      StRead: begin
        cnt_d = cnt_q + CntW'(1);
        if (half_done) begin
          cnt_d = '0;
          if (!phase_q) begin
            // Last cycle of the low phase: capture the bit, LSB first
            phase_d  = 1'b1;
            tm_clk_d = 1'b1;
            shadow_d = {dio_sync_q, shadow_q[31:1]};
          end else if (bit_q == 5'd31) begin
            state_d  = StGap;
            tm_stb_d = 1'b1;
            tm_clk_d = 1'b1;
          end else begin
            phase_d  = 1'b0;
            bit_d    = bit_q + 5'd1;
            tm_clk_d = 1'b0;
          end
        end
      end

      StGap: begin
        cnt_d = cnt_q + CntW'(1);
        if (half_done) begin
          // Results publish together with the return to idle
          state_d   = StIdle;
          cnt_d     = '0;
          busy_d    = 1'b0;
          valid_d   = 1'b1;
          key_raw_d = shadow_q;
          keys_d    = decode_keys(shadow_q);
        end
      end

      default: begin
        state_d   = StIdle;
        busy_d    = 1'b0;
        tm_stb_d  = 1'b1;
        tm_clk_d  = 1'b1;
        dio_out_d = 1'b1;
        dio_oe_d  = 1'b0;
      end
    endcase
  end

  // Scan FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      shadow_q  <= '0;
      key_raw_q <= '0;
      keys_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      tm_stb_q  <= 1'b1;
      tm_clk_q  <= 1'b1;
      dio_out_q <= 1'b1;
      dio_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      shadow_q  <= shadow_d;
      key_raw_q <= key_raw_d;
      keys_q    <= keys_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      tm_stb_q  <= tm_stb_d;
      tm_clk_q  <= tm_clk_d;
      dio_out_q <= dio_out_d;
      dio_oe_q  <= dio_oe_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.keys    = keys_q;
  assign bus.key_raw = key_raw_q;
  assign bus.tm_stb  = tm_stb_q;
  assign bus.tm_clk  = tm_clk_q;
  assign bus.dio_out = dio_out_q;
  assign bus.dio_oe  = dio_oe_q;

endmodule
